dmem_arbiter: RTL and testbench

- Shares the single-port 8-bit data memory between two requesters.
- Port 0 is the CPU data-memory path; port 1 is a debug/loader path that preloads or inspects data memory.
- Round-robin arbitration, one transaction in flight at a time, req/ack handshake per port.
- Sits between the requesters and data_memoryfile, and owns all of that memory's address, data, write-enable and enable pins.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory
// between the CPU data path (port 0) and a debug/loader path (port 1).
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> ACK.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   rN_req/wr/addr/wdata     requester N request and transaction fields
//   rN_ack, rN_rdata         one-cycle completion pulse and read data
//   mem_en/wr/addr/wdata     memory access strobe and fields (all registered)
//   mem_rdata                memory read data, valid RD_LAT cycles after mem_en
//   busy                     high whenever the FSM is not in IDLE
//   gnt_id                   port owning the current or last transaction
module dmem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_wr,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_wr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          gnt_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t     state, state_nx;
    logic       last_srv;
    logic [1:0] cnt;
    logic       lat_wr;
    logic       grant_vld;
    logic       grant_port;

    // Next-state and arbitration. On a tie the port that was not served
    // last wins, which gives strict alternation under contention.
    always_comb begin
        state_nx   = state;
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req && r1_req) begin
                    grant_vld  = 1'b1;
                    grant_port = ~last_srv;
                end else if (r0_req) begin
                    grant_vld  = 1'b1;
                    grant_port = 1'b0;
                end else if (r1_req) begin
                    grant_vld  = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant_vld) state_nx = ISSUE;
            end
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == 2'd0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Registered outputs. mem_addr/mem_wdata keep the granted port's fields
    // after ISSUE, so a non-granted port changing its fields has no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            gnt_id    <= 1'b0;
            last_srv  <= 1'b1;
            cnt       <= 2'd0;
        end else begin
            busy   <= (state_nx != IDLE);
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        gnt_id <= grant_port;
                        mem_en <= 1'b1;
                        if (grant_port) begin
                            mem_wr    <= r1_wr;
                            mem_addr  <= r1_addr;
                            mem_wdata <= r1_wdata;
                            lat_wr    <= r1_wr;
                        end else begin
                            mem_wr    <= r0_wr;
                            mem_addr  <= r0_addr;
                            mem_wdata <= r0_wdata;
                            lat_wr    <= r0_wr;
                        end
                    end
                end
                ISSUE: cnt <= 2'(RD_LAT - 1);
                WAIT: begin
                    if (cnt == 2'd0) begin
                        // Writes leave rdata untouched so it holds the last read.
                        if (gnt_id) begin
                            r1_ack <= 1'b1;
                            if (!lat_wr) r1_rdata <= mem_rdata;
                        end else begin
                            r0_ack <= 1'b1;
                            if (!lat_wr) r0_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK:     last_srv <= gnt_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_req, r0_wr, r1_req, r1_wr;
    logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

    // Instance a: RD_LAT=1, instance b: RD_LAT=3. Both share the requester inputs.
    logic       r0_ack_a, r1_ack_a, mem_en_a, mem_wr_a, busy_a, gnt_id_a;
    logic [7:0] r0_rdata_a, r1_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic       r0_ack_b, r1_ack_b, mem_en_b, mem_wr_b, busy_b, gnt_id_b;
    logic [7:0] r0_rdata_b, r1_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic       pre_en;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rd_b_p1, rd_b_p2, rd_b_p3;

    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack_a), .r0_rdata(r0_rdata_a),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack_a), .r1_rdata(r1_rdata_a),
        .mem_en(mem_en_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .gnt_id(gnt_id_a));

    dmem_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack_b), .r0_rdata(r0_rdata_b),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack_b), .r1_rdata(r1_rdata_b),
        .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .gnt_id(gnt_id_b));

    // Memory models: a reads with one cycle latency, b with three.
    always @(posedge clk) begin
        if (pre_en) mem_a[pre_addr] <= pre_data;
        else if (mem_en_a && mem_wr_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_en_a) mem_rdata_a <= mem_a[mem_addr_a];
    end

    always @(posedge clk) begin
        if (pre_en) mem_b[pre_addr] <= pre_data;
        else if (mem_en_b && mem_wr_b) mem_b[mem_addr_b] <= mem_wdata_b;
        rd_b_p1 <= mem_b[mem_addr_b];
        rd_b_p2 <= rd_b_p1;
        rd_b_p3 <= rd_b_p2;
    end
    assign mem_rdata_b = rd_b_p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic do_reset();
        r0_req = 1'b0; r1_req = 1'b0; r0_wr = 1'b0; r1_wr = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if ({r0_ack_a, r1_ack_a} !== 2'b00) begin miss++; $display("FAIL reset_ack got %b exp 00", {r0_ack_a, r1_ack_a}); end
        vecs++; if ({mem_en_a, mem_wr_a, busy_a, gnt_id_a} !== 4'b0000) begin miss++; $display("FAIL reset_ctl got %b exp 0000", {mem_en_a, mem_wr_a, busy_a, gnt_id_a}); end
        vecs++; if ({r0_rdata_a, r1_rdata_a, mem_addr_a, mem_wdata_a} !== 32'h0) begin miss++; $display("FAIL reset_data got %h exp 0", {r0_rdata_a, r1_rdata_a, mem_addr_a, mem_wdata_a}); end
        vecs++; if ({r0_ack_b, r1_ack_b, mem_en_b, busy_b, gnt_id_b} !== 5'b0) begin miss++; $display("FAIL reset_b got %b exp 00000", {r0_ack_b, r1_ack_b, mem_en_b, busy_b, gnt_id_b}); end
    endtask

    task automatic test_single_read();
        do_reset();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10; r0_wdata = 8'h00;
        tick(); // T+1
        vecs++; if (mem_en_a !== 1'b1) begin miss++; $display("FAIL rd_en got %b exp 1", mem_en_a); end
        vecs++; if (mem_addr_a !== 8'h10) begin miss++; $display("FAIL rd_addr got %h exp 10", mem_addr_a); end
        vecs++; if ({mem_wr_a, busy_a, gnt_id_a} !== 3'b010) begin miss++; $display("FAIL rd_ctl got %b exp 010", {mem_wr_a, busy_a, gnt_id_a}); end
        tick(); // T+2
        vecs++; if ({mem_en_a, r0_ack_a} !== 2'b00) begin miss++; $display("FAIL rd_wait got %b exp 00", {mem_en_a, r0_ack_a}); end
        tick(); // T+3
        vecs++; if (r0_ack_a !== 1'b1) begin miss++; $display("FAIL rd_ack got %b exp 1", r0_ack_a); end
        vecs++; if (r0_rdata_a !== 8'hA5) begin miss++; $display("FAIL rd_data got %h exp a5", r0_rdata_a); end
        vecs++; if (r1_ack_a !== 1'b0) begin miss++; $display("FAIL rd_other_ack got %b exp 0", r1_ack_a); end
        r0_req = 1'b0;
        tick(); // T+4
        vecs++; if ({r0_ack_a, busy_a} !== 2'b00) begin miss++; $display("FAIL rd_done got %b exp 00", {r0_ack_a, busy_a}); end
    endtask

    task automatic test_write_read();
        do_reset();
        r1_req = 1'b1; r1_wr = 1'b1; r1_addr = 8'h7F; r1_wdata = 8'h3C;
        tick(); // T+1
        vecs++; if ({mem_en_a, mem_wr_a, gnt_id_a} !== 3'b111) begin miss++; $display("FAIL wr_issue got %b exp 111", {mem_en_a, mem_wr_a, gnt_id_a}); end
        vecs++; if (mem_wdata_a !== 8'h3C) begin miss++; $display("FAIL wr_wdata got %h exp 3c", mem_wdata_a); end
        tick(); // T+2
        vecs++; if (mem_wr_a !== 1'b0) begin miss++; $display("FAIL wr_wr_low got %b exp 0", mem_wr_a); end
        tick(); // T+3
        vecs++; if (r1_ack_a !== 1'b1) begin miss++; $display("FAIL wr_ack got %b exp 1", r1_ack_a); end
        r1_wr = 1'b0; // req stays high: a new read transaction
        tick(); // T+4 IDLE
        vecs++; if ({mem_en_a, r1_ack_a} !== 2'b00) begin miss++; $display("FAIL wr_idle got %b exp 00", {mem_en_a, r1_ack_a}); end
        tick(); // T+5 ISSUE of the read
        vecs++; if ({mem_en_a, mem_wr_a} !== 2'b10) begin miss++; $display("FAIL wr_rd_issue got %b exp 10", {mem_en_a, mem_wr_a}); end
        tick();
        tick(); // T+7
        vecs++; if ({r1_ack_a, r0_ack_a} !== 2'b10) begin miss++; $display("FAIL wr_rd_ack got %b exp 10", {r1_ack_a, r0_ack_a}); end
        vecs++; if (r1_rdata_a !== 8'h3C) begin miss++; $display("FAIL wr_rd_data got %h exp 3c", r1_rdata_a); end
        vecs++; if (r0_rdata_a !== 8'h00) begin miss++; $display("FAIL wr_r0_hold got %h exp 00", r0_rdata_a); end
        r1_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic e0, e1;
        do_reset();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10;
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 8'h7F;
        for (int c = 1; c <= 15; c++) begin
            tick();
            e0 = (c % 4 == 3) && ((c / 4) % 2 == 0);
            e1 = (c % 4 == 3) && ((c / 4) % 2 == 1);
            vecs++; if ({r0_ack_a, r1_ack_a} !== {e0, e1}) begin miss++; $display("FAIL cont_acks c=%0d got %b exp %b", c, {r0_ack_a, r1_ack_a}, {e0, e1}); end
            if (c % 4 == 3) begin
                vecs++; if (gnt_id_a !== e1) begin miss++; $display("FAIL cont_gnt c=%0d got %b exp %b", c, gnt_id_a, e1); end
                if (e0) begin
                    vecs++; if (r0_rdata_a !== 8'hA5) begin miss++; $display("FAIL cont_r0data c=%0d got %h exp a5", c, r0_rdata_a); end
                end else begin
                    vecs++; if (r1_rdata_a !== 8'h3C) begin miss++; $display("FAIL cont_r1data c=%0d got %h exp 3c", c, r1_rdata_a); end
                end
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
    endtask

    task automatic test_rd_lat3();
        do_reset();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h00;
        for (int c = 1; c <= 5; c++) begin
            tick();
            vecs++; if (mem_en_b !== (c == 1)) begin miss++; $display("FAIL lat3_en c=%0d got %b exp %b", c, mem_en_b, (c == 1)); end
            vecs++; if (busy_b !== 1'b1) begin miss++; $display("FAIL lat3_busy c=%0d got %b exp 1", c, busy_b); end
            vecs++; if (r0_ack_b !== (c == 5)) begin miss++; $display("FAIL lat3_ack c=%0d got %b exp %b", c, r0_ack_b, (c == 5)); end
        end
        vecs++; if (r0_rdata_b !== 8'h5A) begin miss++; $display("FAIL lat3_data got %h exp 5a", r0_rdata_b); end
        r0_req = 1'b0;
        tick(); // T+6
        vecs++; if ({busy_b, r0_ack_b} !== 2'b00) begin miss++; $display("FAIL lat3_done got %b exp 00", {busy_b, r0_ack_b}); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 8'h10;
        tick(); // ISSUE
        tick(); // WAIT
        vecs++; if (busy_a !== 1'b1) begin miss++; $display("FAIL mid_busy got %b exp 1", busy_a); end
        rst = 1'b1;
        tick();
        vecs++; if ({r0_ack_a, r1_ack_a, mem_en_a, mem_wr_a, busy_a, gnt_id_a} !== 6'b0) begin miss++; $display("FAIL mid_ctl got %b exp 000000", {r0_ack_a, r1_ack_a, mem_en_a, mem_wr_a, busy_a, gnt_id_a}); end
        vecs++; if ({r1_rdata_a, mem_addr_a} !== 16'h0) begin miss++; $display("FAIL mid_data got %h exp 0000", {r1_rdata_a, mem_addr_a}); end
        rst = 1'b0;
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10;
        r1_req = 1'b1; r1_addr = 8'h7F;
        tick();
        vecs++; if ({gnt_id_a, mem_en_a} !== 2'b01) begin miss++; $display("FAIL mid_tie got %b exp 01", {gnt_id_a, mem_en_a}); end
        vecs++; if (mem_addr_a !== 8'h10) begin miss++; $display("FAIL mid_addr got %h exp 10", mem_addr_a); end
        tick();
        tick();
        vecs++; if ({r0_ack_a, r1_ack_a} !== 2'b10) begin miss++; $display("FAIL mid_ack got %b exp 10", {r0_ack_a, r1_ack_a}); end
        vecs++; if (r0_rdata_a !== 8'hA5) begin miss++; $display("FAIL mid_rdata got %h exp a5", r0_rdata_a); end
        r0_req = 1'b0; r1_req = 1'b0;
        tick();
    endtask

    task automatic test_stability();
        do_reset();
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 8'h10;
        tick(); // T+1
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 8'h55;
        vecs++; if (mem_addr_a !== 8'h10) begin miss++; $display("FAIL stab_addr1 got %h exp 10", mem_addr_a); end
        tick(); // T+2
        r1_addr = 8'h66;
        vecs++; if (mem_addr_a !== 8'h10) begin miss++; $display("FAIL stab_addr2 got %h exp 10", mem_addr_a); end
        tick(); // T+3
        vecs++; if ({r0_ack_a, r0_rdata_a} !== {1'b1, 8'hA5}) begin miss++; $display("FAIL stab_r0 got %h exp 1a5", {r0_ack_a, r0_rdata_a}); end
        r0_req = 1'b0;
        tick(); // T+4 IDLE grants port 1
        tick(); // T+5 ISSUE
        vecs++; if ({gnt_id_a, mem_addr_a} !== {1'b1, 8'h66}) begin miss++; $display("FAIL stab_r1_issue got %h exp 166", {gnt_id_a, mem_addr_a}); end
        tick();
        tick(); // T+7
        vecs++; if ({r1_ack_a, r0_ack_a} !== 2'b10) begin miss++; $display("FAIL stab_r1_ack got %b exp 10", {r1_ack_a, r0_ack_a}); end
        vecs++; if (r0_rdata_a !== 8'hA5) begin miss++; $display("FAIL stab_r0_hold got %h exp a5", r0_rdata_a); end
        r1_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        r0_req = 1'b0; r0_wr = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_wr = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
        pre_en = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        tick();
        preload(8'h10, 8'hA5);
        preload(8'h00, 8'h5A);
        preload(8'h66, 8'h00);
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_rd_lat3();
        test_reset_midop();
        test_stability();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
